i2c_byte_master: RTL and testbench

Single-byte I2C bus master that executes the transactions the address translator issues on its downstream request interface. It accepts one start/addr/rw/wr_data request and generates START, the 7-bit address plus R/W bit, one data byte and STOP on open-drain SCL/SDA. It then returns rd_data, done and ack_error to the requester. It sits between the address translator and the pad-level open-drain buffers.

---
 rtl/i2c_byte_master.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_master.sv
// Single-byte I2C bus master for a single-master bus.
// Takes one start/addr/rw/wr_data request. Drives START, the address plus R/W bit,
// one data byte and STOP on open-drain SCL/SDA. Returns rd_data, done and ack_error.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start               request strobe, sampled only while idle
//   addr, rw, wr_data   7-bit target address, 1 = read, byte to write
//   rd_data             last successfully read byte
//   busy                transaction in progress
//   done                one-cycle completion pulse
//   ack_error           NACK status, valid only while done=1
//   scl_oe, sda_oe      1 = pull the line low, 0 = release
//   scl_in, sda_in      asynchronous pad levels
module i2c_byte_master #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StAddr, StAddrAck, StData, StDataAck, StStop, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      settle_q, settle_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            rw_q, rw_d;
  logic            err_q, err_d;
  logic [1:0]      scl_sync_q, sda_sync_q;
  logic            scl_s, sda_s;
  logic            active, tick;
  logic            scl_oe_d, sda_oe_d;

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    err_d    = err_q;
    settle_d = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;
    active   = (state_q != StIdle) && (state_q != StDone);
    tick     = active && (cnt_q == '0);

    if (state_q == StIdle) begin
      if (start) begin
        state_d  = StStart;
        cnt_d    = Reload;
        qtr_d    = 2'd0;
        bit_d    = 3'd0;
        sh_d     = {addr, rw};
        wdata_d  = wr_data;
        rw_d     = rw;
        err_d    = 1'b0;
        settle_d = 2'd0;
      end
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end else if (tick) begin
      cnt_d = Reload;
      qtr_d = qtr_q + 2'd1;
      // The synchronizer lags a released SCL by two edges. Skip the stretch check
      // for those edges so an unstretched Q2 keeps its nominal length.
      if (qtr_q == 2'd1) settle_d = 2'd2;
      if (qtr_q == 2'd3) begin
        unique case (state_q)
          StStart: begin
            state_d = StAddr;
            bit_d   = 3'd0;
          end
          StAddr: begin
            sh_d  = {sh_q[6:0], sda_s};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StAddrAck;
          end
          StAddrAck: begin
            if (sda_s) begin
              err_d   = 1'b1;
              state_d = StStop;
            end else begin
              state_d = StData;
              bit_d   = 3'd0;
              sh_d    = wdata_q;
            end
          end
          StData: begin
            // Same shift for both directions: writes push bits out of the MSB,
            // reads collect sampled bits into the LSB.
            sh_d  = {sh_q[6:0], sda_s};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StDataAck;
          end
          StDataAck: begin
            if (!rw_q && sda_s) err_d = 1'b1;
            state_d = StStop;
          end
          StStop:  state_d = StDone;
          default: state_d = StIdle;
        endcase
      end
    end else if (qtr_q == 2'd2 && settle_q == 2'd0 && !scl_s) begin
      cnt_d = Reload;  // slave stretching SCL
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Line drive follows the next state so the pad outputs come straight from flops.
  always_comb begin
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    unique case (state_d)
      StStart: sda_oe_d = qtr_d[1];
      StAddr: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = !sh_d[7];
      end
      StData: begin
        scl_oe_d = !qtr_d[1];
        sda_oe_d = !rw_d && !sh_d[7];
      end
      StAddrAck, StDataAck: scl_oe_d = !qtr_d[1];
      StStop: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = !qtr_d[1];
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd0;
      settle_q   <= 2'd0;
      sh_q       <= 8'h00;
      wdata_q    <= 8'h00;
      rw_q       <= 1'b0;
      err_q      <= 1'b0;
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      rd_data    <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_error  <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      settle_q   <= settle_d;
      sh_q       <= sh_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      err_q      <= err_d;
      scl_oe     <= scl_oe_d;
      sda_oe     <= sda_oe_d;
      busy       <= (state_d != StIdle) && (state_d != StDone);
      done       <= (state_d == StDone);
      ack_error  <= (state_d == StDone) && err_q;
      // err_q doubles as the address-NACK flag for reads: a read never errors on data.
      if (state_d == StDone && rw_q && !err_q) rd_data <= sh_q;
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with CLK_DIV=4 and a clocked slave model on the pads.
module tb_i2c_byte_master;

  localparam int unsigned Div = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy, done, ack_error, scl_oe, sda_oe;
  logic       scl_pad, sda_pad;

  // Slave model state and configuration
  localparam int SlIdle = 0, SlAddr = 1, SlAack = 2, SlWdata = 3, SlWack = 4,
                 SlRdata = 5, SlRack = 6;
  int         sl_st = SlIdle;
  logic [7:0] sl_sh = 8'h00;
  logic [3:0] sl_cnt = 4'd0;
  logic       sl_sda_low = 1'b0, sl_scl_low = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         str_cnt = 0;
  logic [6:0] slave_addr = 7'h20;
  logic       ack_data = 1'b1;
  logic       stretch_en = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  logic [7:0] addr_seen = 8'h00, data_seen = 8'h00;
  logic       mack = 1'b0;
  int         n_start = 0, n_stop = 0, n_rise = 0;

  int n_checks = 0;
  int n_err = 0;

  assign scl_pad = ~(scl_oe | sl_scl_low);
  assign sda_pad = ~(sda_oe | sl_sda_low);

  i2c_byte_master #(.CLK_DIV(Div)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .addr      (addr),
    .rw        (rw),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .ack_error (ack_error),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .scl_in    (scl_pad),
    .sda_in    (sda_pad)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    scl_p <= scl_pad;
    sda_p <= sda_pad;
    if (sl_scl_low && !scl_oe) begin
      str_cnt <= str_cnt + 1;
      if (str_cnt == 36) sl_scl_low <= 1'b0;
    end
    if (scl_p && scl_pad && sda_p && !sda_pad) begin
      n_start    <= n_start + 1;
      sl_st      <= SlAddr;
      sl_cnt     <= 4'd0;
      sl_sda_low <= 1'b0;
    end else if (scl_p && scl_pad && !sda_p && sda_pad) begin
      n_stop     <= n_stop + 1;
      sl_st      <= SlIdle;
      sl_sda_low <= 1'b0;
    end else if (!scl_p && scl_pad) begin
      n_rise <= n_rise + 1;
      case (sl_st)
        SlAddr, SlWdata: begin
          sl_sh  <= {sl_sh[6:0], sda_pad};
          sl_cnt <= sl_cnt + 4'd1;
        end
        SlRdata: sl_cnt <= sl_cnt + 4'd1;
        SlRack:  mack <= sda_pad;
        default: ;
      endcase
    end else if (scl_p && !scl_pad) begin
      case (sl_st)
        SlAddr: begin
          if (sl_cnt == 4'd8) begin
            addr_seen <= sl_sh;
            if (sl_sh[7:1] == slave_addr) begin
              sl_sda_low <= 1'b1;
              sl_st      <= SlAack;
            end else begin
              sl_st <= SlIdle;
            end
          end else if (sl_cnt == 4'd3 && stretch_en) begin
            sl_scl_low <= 1'b1;
            str_cnt    <= 0;
          end
        end
        SlAack: begin
          sl_cnt <= 4'd0;
          if (sl_sh[0]) begin
            sl_st      <= SlRdata;
            sl_sda_low <= !rd_byte[7];
          end else begin
            sl_st      <= SlWdata;
            sl_sda_low <= 1'b0;
          end
        end
        SlWdata: begin
          if (sl_cnt == 4'd8) begin
            data_seen  <= sl_sh;
            sl_sda_low <= ack_data;
            sl_st      <= SlWack;
          end
        end
        SlWack: begin
          sl_sda_low <= 1'b0;
          sl_st      <= SlIdle;
        end
        SlRdata: begin
          if (sl_cnt == 4'd8) begin
            sl_sda_low <= 1'b0;
            sl_st      <= SlRack;
          end else begin
            sl_sda_low <= !rd_byte[3'(7 - sl_cnt)];
          end
        end
        SlRack:  sl_st <= SlIdle;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one request. dcyc = cycle (1 = cycle after the accepting edge) where done
  // was seen, 0 if none. poke_cyc pulses start mid-transfer; rst_cyc aborts with reset.
  task automatic xfer(input logic [6:0] a, input logic r, input logic [7:0] d,
                      input int poke_cyc, input int rst_cyc, output int dcyc);
    int   cyc;
    logic aborted;
    aborted = 1'b0;
    dcyc    = 0;
    @(negedge clk);
    addr = a; rw = r; wr_data = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    check("busy_after_accept", 32'(busy), 1);
    while (cyc < 3000) begin
      if (cyc == poke_cyc) begin
        addr = 7'h21; rw = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (cyc == rst_cyc) begin
        check("pre_rst_scl_oe", 32'(scl_oe), 1);
        check("pre_rst_sda_oe", 32'(sda_oe), 1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_scl_oe", 32'(scl_oe), 0);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_busy", 32'(busy), 0);
        aborted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    start = 1'b0;
    if (!aborted && dcyc == 0) check("done_seen", 32'(done), 1);
  endtask

  initial begin
    int dc, b_rise, b_start, b_stop, nb;
    rst_n = 1'b0; start = 1'b0; addr = 7'h00; rw = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_data", 32'(rd_data), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_ack_error", 32'(ack_error), 0);
    check("reset_scl_oe", 32'(scl_oe), 0);
    check("reset_sda_oe", 32'(sda_oe), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Write 0xA5 to 0x20, all ACKed
    slave_addr = 7'h20; ack_data = 1'b1;
    b_rise = n_rise; b_start = n_start; b_stop = n_stop;
    xfer(7'h20, 1'b0, 8'hA5, 0, 0, dc);
    check("wr_done_cycle", 32'(dc), 321);
    check("wr_ack_error", 32'(ack_error), 0);
    check("wr_busy_at_done", 32'(busy), 0);
    check("wr_rd_data_kept", 32'(rd_data), 0);
    check("wr_addr_byte", 32'(addr_seen), 32'h40);
    check("wr_data_byte", 32'(data_seen), 32'hA5);
    check("wr_scl_rises", 32'(n_rise - b_rise), 19);
    check("wr_starts", 32'(n_start - b_start), 1);
    check("wr_stops", 32'(n_stop - b_stop), 1);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 0);
    repeat (3) @(posedge clk);

    // Read from 0x21, slave returns 0x3C; then a start coincident with done
    slave_addr = 7'h21; rd_byte = 8'h3C;
    xfer(7'h21, 1'b1, 8'h00, 0, 0, dc);
    check("rd_done_cycle", 32'(dc), 321);
    check("rd_data", 32'(rd_data), 32'h3C);
    check("rd_ack_error", 32'(ack_error), 0);
    check("rd_master_nack", 32'(mack), 1);
    check("rd_addr_byte", 32'(addr_seen), 32'h43);
    addr = 7'h21; rw = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_at_done_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    check("start_at_done_busy2", 32'(busy), 0);
    repeat (3) @(posedge clk);

    // Address NACK: nobody at 0x7F
    b_rise = n_rise; b_stop = n_stop;
    xfer(7'h7F, 1'b1, 8'h00, 0, 0, dc);
    check("nack_done_cycle", 32'(dc), 44 * Div + 1);
    check("nack_ack_error", 32'(ack_error), 1);
    check("nack_rd_data_kept", 32'(rd_data), 32'h3C);
    check("nack_scl_rises", 32'(n_rise - b_rise), 10);
    check("nack_stops", 32'(n_stop - b_stop), 1);
    repeat (3) @(posedge clk);

    // Write with data NACK
    slave_addr = 7'h20; ack_data = 1'b0;
    xfer(7'h20, 1'b0, 8'hC3, 0, 0, dc);
    check("dnack_done_cycle", 32'(dc), 321);
    check("dnack_ack_error", 32'(ack_error), 1);
    check("dnack_data_byte", 32'(data_seen), 32'hC3);
    check("dnack_rd_data_kept", 32'(rd_data), 32'h3C);
    repeat (3) @(posedge clk);

    // Slave stretches SCL by 37 cycles in address slot 3
    ack_data = 1'b1; stretch_en = 1'b1;
    xfer(7'h20, 1'b0, 8'h5A, 0, 0, dc);
    stretch_en = 1'b0;
    check("stretch_delay_in_range", 32'((dc - 321 >= 37) && (dc - 321 <= 39)), 1);
    check("stretch_addr_byte", 32'(addr_seen), 32'h40);
    check("stretch_data_byte", 32'(data_seen), 32'h5A);
    check("stretch_ack_error", 32'(ack_error), 0);
    repeat (3) @(posedge clk);

    // Start pulsed while busy is ignored
    b_start = n_start;
    xfer(7'h20, 1'b0, 8'h96, 100, 0, dc);
    check("poke_done_cycle", 32'(dc), 321);
    check("poke_data_byte", 32'(data_seen), 32'h96);
    nb = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (busy) nb++;
    end
    check("poke_no_second_busy", 32'(nb), 0);
    check("poke_one_start", 32'(n_start - b_start), 1);

    // Reset in the middle of DATA, then a normal write
    xfer(7'h20, 1'b0, 8'h00, 0, 200, dc);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("after_rst_rd_data", 32'(rd_data), 0);
    repeat (5) @(posedge clk);
    xfer(7'h20, 1'b0, 8'h81, 0, 0, dc);
    check("post_rst_done_cycle", 32'(dc), 321);
    check("post_rst_ack_error", 32'(ack_error), 0);
    check("post_rst_addr_byte", 32'(addr_seen), 32'h40);
    check("post_rst_data_byte", 32'(data_seen), 32'h81);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
